multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle CPU datapath one instruction at a time.
- Consumes opcode and funct fields from the instruction register.
- Drives every datapath control strobe: PC/IR/register/memory enables, mux selects, ALU operation.
- Also keeps a retired-instruction counter and flags illegal encodings, halting until reset.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter Instr_count.

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- Funct  in  6  instruction bits [5:0] (immediate[5:0]) from the instruction register
- PC_write  out  1  unconditional PC load
- Branch  out  1  conditional PC load; datapath ANDs with ALU zero
- PC_src  out  1  0 = PC from live ALU result, 1 = PC from ALU-out register
- Reg_write  out  1  register-file write enable
- Mem_to_reg  out  1  1 = write-back from memory-data register, 0 = from ALU-out register
- Reg_dst  out  1  1 = destination is rd (bits 15:11), 0 = rt
- IorD  out  1  0 = instruction access, 1 = data access
- Mem_write  out  1  data-memory write enable
- IR_write  out  1  instruction-register load
- ALU_src_a  out  1  1 = PC, 0 = register A
- ALU_src_b  out  2  0 = register B, 1 = constant 1, 2 = sign-extended immediate, 3 = zero-extended immediate
- ALU_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- Illegal  out  1  high while halted on an undecodable instruction
- Instr_count  out  COUNT_W  instructions retired since reset

Behaviour:
- Reset
  - Reset low asynchronously forces state IDLE and Instr_count = 0.
  - IDLE drives every output 0.
  - IDLE -> FETCH on the first rising edge after Reset is released.
- Outputs are pure decodes of the current state; they depend only on state, never on Opcode or Funct directly. Exception: ALU_control in R_EXEC also decodes the latched Funct.
- Any strobe not listed for a state is 0. ALU_control defaults to 010.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ORI 001101.
- Funct codes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- States, strobes and transitions:
  - FETCH: IR_write=1, PC_write=1, ALU_src_a=1, ALU_src_b=1, ALU_control=ADD, PC_src=0 (PC <= PC+1, word addressed). -> DECODE.
  - DECODE: ALU_src_a=1, ALU_src_b=2, ALU_control=ADD (branch target PC+1+imm into ALU-out). Next state by Opcode:
    - LW or SW -> MEM_ADDR
    - R -> R_EXEC
    - BEQ -> BRANCH
    - ADDI -> ADDI_EXEC
    - ORI -> ORI_EXEC
    - anything else -> ILLEGAL
  - MEM_ADDR: ALU_src_b=2, ADD. -> MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ: IorD=1. -> MEM_WB.
  - MEM_WB: Reg_write=1, Mem_to_reg=1, Reg_dst=0. -> FETCH.
  - MEM_WRITE: IorD=1, Mem_write=1. -> FETCH.
  - R_EXEC: ALU_src_b=0, ALU_control from Funct. Unknown Funct -> ILLEGAL, otherwise -> R_WB.
  - R_WB: Reg_write=1, Reg_dst=1. -> FETCH.
  - BRANCH: ALU_src_b=0, SUB, Branch=1, PC_src=1. -> FETCH.
  - ADDI_EXEC: ALU_src_b=2, ADD. -> ADDI_WB.
  - ORI_EXEC: ALU_src_b=3, OR. -> ORI_WB.
  - ADDI_WB / ORI_WB: Reg_write=1, Reg_dst=0. -> FETCH.
  - ILLEGAL: all strobes 0, Illegal=1; stays until Reset.
- Cycles per instruction, FETCH inclusive: LW 5, SW 4, R 4, ADDI 4, ORI 4, BEQ 3.
- Instr_count
  - Increments by 1 on the clock edge leaving MEM_WB, MEM_WRITE, R_WB, BRANCH, ADDI_WB or ORI_WB.
  - Wraps from all-ones to 0.
  - Never increments for ILLEGAL.
- Opcode and Funct are sampled only in DECODE / R_EXEC. Changes in any other state are ignored.
- Reset asserted mid-instruction aborts it immediately. All strobes drop in the same cycle, with no partial writes after the edge, and the count is not incremented.
- Write enables (PC_write, IR_write, Reg_write, Mem_write, Branch) are never asserted in two consecutive states of the same instruction except FETCH.

Test Plan:
- Reset low 3 cycles, release, Opcode=100011 -> IDLE 1 cycle with all outputs 0; FETCH shows IR_write=PC_write=1; sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; Mem_to_reg=1 with Reg_write=1 in cycle 5; Instr_count=1.
- Opcode=000000, Funct=100010 -> R_EXEC drives ALU_control=110, ALU_src_b=0; R_WB drives Reg_write=1, Reg_dst=1; 4 cycles total.
- Opcode=000100 -> 3-cycle instruction; BRANCH drives Branch=1, PC_src=1, ALU_control=110, PC_write=0.
- Opcode=001101 then 001000 -> ORI_EXEC ALU_src_b=3, ALU_control=001; ADDI_EXEC ALU_src_b=2, ALU_control=010; Instr_count advances 2.
- Opcode=111111, or Opcode=000000 with Funct=000001 -> ILLEGAL; Illegal=1 held 20 cycles, all strobes 0, count frozen; Reset low restores IDLE and count 0.
- Reset pulsed low during MEM_WRITE of SW -> Mem_write drops asynchronously, Instr_count unchanged (0); load Instr_count near wrap (COUNT_W=4, 16 instructions) -> rolls 15 -> 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: Moore FSM that sequences one instruction at a
// time through fetch, decode, execute, memory and write-back, drives every
// datapath strobe, counts retired instructions and halts on bad encodings.
module multicycle_control #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    output logic               PC_write,
    output logic               Branch,
    output logic               PC_src,
    output logic               Reg_write,
    output logic               Mem_to_reg,
    output logic               Reg_dst,
    output logic               IorD,
    output logic               Mem_write,
    output logic               IR_write,
    output logic               ALU_src_a,
    output logic [1:0]         ALU_src_b,
    output logic [2:0]         ALU_control,
    output logic               Illegal,
    output logic [COUNT_W-1:0] Instr_count
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, ORI_EXEC, ORI_WB, ILLEGAL
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t             state_q, state_d;
    logic               store_q, store_d;   // load/store choice captured in DECODE
    logic [COUNT_W-1:0] count_q, count_d;

    // State, store flag and retired counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            count_q <= count_d;
        end
    end

    assign Instr_count = count_q;

    // Next-state, per-state strobe decode and retirement increment.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        count_d     = count_q;
        PC_write    = 1'b0;
        Branch      = 1'b0;
        PC_src      = 1'b0;
        Reg_write   = 1'b0;
        Mem_to_reg  = 1'b0;
        Reg_dst     = 1'b0;
        IorD        = 1'b0;
        Mem_write   = 1'b0;
        IR_write    = 1'b0;
        ALU_src_a   = 1'b0;
        ALU_src_b   = 2'd0;
        ALU_control = ALU_ADD;
        Illegal     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ALU_control = 3'b000;
                state_d     = FETCH;
            end
            FETCH: begin
                IR_write  = 1'b1;
                PC_write  = 1'b1;
                ALU_src_a = 1'b1;
                ALU_src_b = 2'd1;
                state_d   = DECODE;
            end
            DECODE: begin
                ALU_src_a = 1'b1;
                ALU_src_b = 2'd2;
                store_d   = (Opcode == OP_SW);
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_R:         state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    OP_ORI:       state_d = ORI_EXEC;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                ALU_src_b = 2'd2;
                state_d   = store_q ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                IorD    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                Reg_write  = 1'b1;
                Mem_to_reg = 1'b1;
                state_d    = FETCH;
                count_d    = count_q + COUNT_W'(1);
            end
            MEM_WRITE: begin
                IorD      = 1'b1;
                Mem_write = 1'b1;
                state_d   = FETCH;
                count_d   = count_q + COUNT_W'(1);
            end
            R_EXEC: begin
                state_d = R_WB;
                case (Funct)
                    6'b100000: ALU_control = ALU_ADD;
                    6'b100010: ALU_control = ALU_SUB;
                    6'b100100: ALU_control = ALU_AND;
                    6'b100101: ALU_control = ALU_OR;
                    6'b101010: ALU_control = ALU_SLT;
                    default:   state_d     = ILLEGAL;
                endcase
            end
            R_WB: begin
                Reg_write = 1'b1;
                Reg_dst   = 1'b1;
                state_d   = FETCH;
                count_d   = count_q + COUNT_W'(1);
            end
            BRANCH: begin
                ALU_control = ALU_SUB;
                Branch      = 1'b1;
                PC_src      = 1'b1;
                state_d     = FETCH;
                count_d     = count_q + COUNT_W'(1);
            end
            ADDI_EXEC: begin
                ALU_src_b = 2'd2;
                state_d   = ADDI_WB;
            end
            ORI_EXEC: begin
                ALU_src_b   = 2'd3;
                ALU_control = ALU_OR;
                state_d     = ORI_WB;
            end
            ADDI_WB, ORI_WB: begin
                Reg_write = 1'b1;
                state_d   = FETCH;
                count_d   = count_q + COUNT_W'(1);
            end
            ILLEGAL: begin
                Illegal = 1'b1;
                state_d = ILLEGAL;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model produces the
// expected output vector for every cycle of each instruction; one compare
// process checks the DUT on each falling edge, plus literal spot checks.
module tb_multicycle_control;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] Opcode = '0;
    logic [5:0] Funct = '0;
    logic PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst;
    logic IorD, Mem_write, IR_write, ALU_src_a, Illegal;
    logic [1:0] ALU_src_b;
    logic [2:0] ALU_control;
    logic [3:0] Instr_count;

    int total = 0;
    int bad = 0;
    logic [3:0]  model_cnt = '0;
    logic [19:0] expq[$];

    multicycle_control #(.COUNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
        .PC_write(PC_write), .Branch(Branch), .PC_src(PC_src),
        .Reg_write(Reg_write), .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst),
        .IorD(IorD), .Mem_write(Mem_write), .IR_write(IR_write),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_control(ALU_control),
        .Illegal(Illegal), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    function automatic logic [19:0] dutv();
        return {PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD,
                Mem_write, IR_write, ALU_src_a, ALU_src_b, ALU_control, Illegal,
                Instr_count};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            F_ADD:   return 3'b010;
            F_SUB:   return 3'b110;
            F_AND:   return 3'b000;
            F_OR:    return 3'b001;
            F_SLT:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] fn);
        return fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction

    function automatic int unsigned cpi(input logic [5:0] op);
        case (op)
            LW:      return 5;
            BEQ:     return 3;
            default: return 4;
        endcase
    endfunction

    // Expected outputs for step k of an instruction (k=0 is the fetch cycle).
    function automatic logic [19:0] expv(input logic [5:0] op, input logic [5:0] fn,
                                         input int unsigned k, input logic [3:0] cnt);
        logic pcw, br, pcs, rw, m2r, rd, iord, mw, irw, sa, ill;
        logic [1:0] sb;
        logic [2:0] alu;
        {pcw, br, pcs, rw, m2r, rd, iord, mw, irw, sa, ill} = '0;
        sb  = 2'd0;
        alu = 3'b010;
        if (k == 0) begin
            irw = 1; pcw = 1; sa = 1; sb = 2'd1;
        end else if (k == 1) begin
            sa = 1; sb = 2'd2;
        end else begin
            case (op)
                LW:   if (k == 2) sb = 2'd2; else if (k == 3) iord = 1;
                      else begin rw = 1; m2r = 1; end
                SW:   if (k == 2) sb = 2'd2; else begin iord = 1; mw = 1; end
                RT:   if (!funct_ok(fn)) ill = (k >= 3);
                      else if (k == 2) alu = funct_alu(fn);
                      else begin rw = 1; rd = 1; end
                BEQ:  begin alu = 3'b110; br = 1; pcs = 1; end
                ADDI: if (k == 2) sb = 2'd2; else rw = 1;
                ORI:  if (k == 2) begin sb = 2'd3; alu = 3'b001; end else rw = 1;
                default: ill = 1;
            endcase
        end
        return {pcw, br, pcs, rw, m2r, rd, iord, mw, irw, sa, sb, alu, ill, cnt};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison against the model queue.
    always @(negedge Clock) begin
        if (expq.size() > 0) begin
            logic [19:0] e;
            e = expq.pop_front();
            total++;
            if (dutv() !== e) begin
                bad++;
                $display("FAIL cycle_vec @%0t: got %b want %b", $time, dutv(), e);
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_outputs", int'(dutv()), 0);
        Reset = 1'b1;
        model_cnt = '0;
        expq.push_back(20'd0);  // IDLE: every output 0
        @(posedge Clock);
        #1;
    endtask

    // Runs one instruction from FETCH; opcode is scrambled after decode.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        int unsigned n;
        n = cpi(op);
        for (int unsigned k = 0; k < n; k++) expq.push_back(expv(op, fn, k, model_cnt));
        Opcode = op;
        Funct  = fn;
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
            if (k == 1) Opcode = 6'b111111;
        end
        model_cnt = model_cnt + 4'd1;
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input int unsigned hold);
        int unsigned n;
        n = ((op == RT) ? 3 : 2) + hold;
        for (int unsigned k = 0; k < n; k++) expq.push_back(expv(op, fn, k, model_cnt));
        Opcode = op;
        Funct  = fn;
        repeat (n) @(posedge Clock);
        #1;
        chk("illegal_flag", int'(Illegal), 1);
        do_reset();
        chk("count_after_reset", int'(Instr_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("fetch_ir_write", int'(IR_write), 1);
        chk("fetch_pc_write", int'(PC_write), 1);
        run_instr(LW, 6'd0);
        chk("count_after_lw", int'(Instr_count), 1);
        run_instr(RT, F_SUB);
        run_instr(BEQ, 6'd0);
        run_instr(ORI, 6'd5);
        run_instr(ADDI, 6'd9);
        run_instr(RT, F_ADD);
        run_instr(RT, F_AND);
        run_instr(RT, F_OR);
        run_instr(RT, F_SLT);
        run_instr(SW, 6'd0);
        chk("count_after_ten", int'(Instr_count), 10);

        run_illegal(6'b111111, 6'd0, 20);
        run_instr(ADDI, 6'd1);
        run_illegal(RT, 6'b000001, 20);

        // Reset during MEM_WRITE of a store.
        for (int unsigned k = 0; k < 3; k++) expq.push_back(expv(SW, 6'd0, k, model_cnt));
        Opcode = SW;
        repeat (3) @(posedge Clock);
        #1;
        chk("sw_mem_write_on", int'(Mem_write), 1);
        #2 Reset = 1'b0;
        #1;
        chk("sw_mem_write_abort", int'(Mem_write), 0);
        chk("sw_iord_abort", int'(IorD), 0);
        chk("sw_count_abort", int'(Instr_count), 0);
        do_reset();

        // Counter wrap on a 4-bit count.
        for (int unsigned i = 0; i < 15; i++) run_instr(ADDI, 6'd2);
        chk("count_15", int'(Instr_count), 15);
        run_instr(ADDI, 6'd2);
        chk("count_wrap", int'(Instr_count), 0);

        repeat (2) @(posedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
